axil_reg_slave: RTL and testbench
=================================

Name: axil_reg_slave

Overview:
- AXI4-Lite slave register bank; the responder end of the AXI4-Lite master used by the block-design test benches.
- Holds NUM_REGS 32-bit read/write registers, byte-maskable through WSTRB.
- Presents all register contents and per-register write strobes to fabric logic.
- One outstanding write and one outstanding read at a time; the write and read paths run independently.

Parameters:
- DATA_WIDTH, 32, AXI data width and register width; only 32 is supported.
- ADDR_WIDTH, 4, AXI address width in bits; decoded index is addr[ADDR_WIDTH-1:2].
- NUM_REGS, 4, number of implemented registers; must be ≤ 2^(ADDR_WIDTH-2).

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- reg_q  out  NUM_REGS*DATA_WIDTH  register contents; reg i at bits [i*32+31:i*32]
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse, coincident with reg i update

Behaviour:
- Reset (ARESET=1 at clock edge):
  - All registers, reg_wr_pulse, BVALID, RVALID, BRESP, RRESP, RDATA go to 0.
  - AWREADY, WREADY, ARREADY go to 1.
  - Any in-flight transaction is discarded, with no response issued.
- Write path states: W_COLLECT, W_RESP.
  - W_COLLECT:
    - AWREADY=1 until AW is captured into a holding register; then 0.
    - WREADY=1 until W (data + strobe) is captured; then 0.
    - AW and W may arrive in either order or in the same cycle.
  - Edge at which the second of AW/W is captured (or both together) = cycle N.
    - At N+1: target register updated per WSTRB (byte k written only if WSTRB[k]=1).
    - At N+1: reg_wr_pulse[idx]=1 for exactly one cycle.
    - At N+1: BVALID=1, BRESP=OKAY; state becomes W_RESP.
  - W_RESP:
    - AWREADY=WREADY=0.
    - BVALID and BRESP held stable until BREADY=1.
    - On the B handshake edge: BVALID=0, AWREADY=WREADY=1, state returns to W_COLLECT.
  - Minimum write cost: 2 cycles per transaction when BREADY is held high.
  - WSTRB=0: no register change, no reg_wr_pulse; response still OKAY.
- Read path states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1.
  - AR handshake at cycle N:
    - At N+1: RVALID=1, RDATA = register contents sampled at edge N, RRESP=OKAY.
    - At N+1: ARREADY=0; state becomes R_DATA.
  - R_DATA:
    - RDATA and RRESP held stable until RREADY=1.
    - On that edge: RVALID=0, ARREADY=1.
- Address decode:
  - idx = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored, so unaligned accesses hit the containing word.
  - idx ≥ NUM_REGS is out of range.
  - Out-of-range write: no register change, no pulse.
  - Out-of-range read: RDATA=0.
- Simultaneous write and read to the same register:
  - Read returns the pre-write value.
  - Write completes normally.
- No combinational path from any input to any *READY or *VALID output; every handshake output is registered.

Optional Feature:
- Macro: AXIL_REG_SLVERR_EN.
- Defined: out-of-range write returns BRESP=SLVERR (2'b10); out-of-range read returns RRESP=SLVERR with RDATA=0.
- Undefined: out-of-range accesses return OKAY; out-of-range writes are silently dropped and reads return 0.
- In-range behaviour is identical in both builds.

Test Plan:
- Sequential fill: write 0x1, 0x2, 0x3, 0x4 to addresses 0x0/0x4/0x8/0xC, then read all four back.
  - Required: every BRESP=OKAY; reads return 0x1..0x4; reg_q = 0x00000004_00000003_00000002_00000001.
- Byte strobe: reg0=0xAABBCCDD, then write 0x11223344 to 0x0 with WSTRB=4'b0101.
  - Required: reg0=0xAA22CC44; reg_wr_pulse[0] high exactly one cycle.
- Channel ordering: W presented 3 cycles before AW, then AW before W, then both in the same cycle (data 0x5A5A0001..3, addr 0x4).
  - Required: each sets reg1 to its data; BVALID appears 1 cycle after the later handshake.
- Backpressure: hold BREADY=0 for 5 cycles after a write and RREADY=0 for 5 cycles after a read of 0x8.
  - Required: BVALID/RVALID, BRESP/RRESP and RDATA stay stable; AWREADY/WREADY/ARREADY stay 0 until the handshake.
- Out of range with NUM_REGS=3: write 0xDEADBEEF to 0xC, then read 0xC.
  - Required: reg0–reg2 unchanged; RDATA=0.
  - BRESP/RRESP = SLVERR with AXIL_REG_SLVERR_EN defined; OKAY without it.
- Reset mid-operation: assert ARESET in the cycle after the AW handshake, before W arrives.
  - Required: next cycle all registers 0, BVALID=0, AWREADY=WREADY=ARREADY=1; no B response ever issued.

Source files
------------

// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite register bank of NUM_REGS byte-maskable 32-bit registers.
// Optional build macro AXIL_REG_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                   S_AXI_AWPROT,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                   S_AXI_ARPROT,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]          reg_wr_pulse
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [1:0] OKAY = 2'b00;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif
    typedef enum logic {W_COLLECT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    wstate_t wstate_q;
    rstate_t rstate_q;
    logic awready_q, wready_q, aw_have_q, w_have_q, bvalid_q;
    logic arready_q, rvalid_q;
    logic [1:0] bresp_q, rresp_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [SW-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pulse_q;
    logic aw_fire, w_fire, commit;
    logic [ADDR_WIDTH-1:0] awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_d, rdata_d;
    logic [SW-1:0] wstrb_d;
    logic [IW-1:0] widx, ridx;
    logic w_in_range, r_in_range;
    logic [NUM_REGS-1:0] wsel_d;
    logic unused_ok;
    // Merge captured and live AW/W beats so a write commits on the edge its second half arrives.
    always_comb begin
        aw_fire = awready_q & S_AXI_AWVALID;
        w_fire = wready_q & S_AXI_WVALID;
        awaddr_d = aw_have_q ? awaddr_q : S_AXI_AWADDR;
        wdata_d = w_have_q ? wdata_q : S_AXI_WDATA;
        wstrb_d = w_have_q ? wstrb_q : S_AXI_WSTRB;
        commit = (wstate_q == W_COLLECT) && (aw_have_q || aw_fire) && (w_have_q || w_fire);
        widx = awaddr_d[ADDR_WIDTH-1:2];
        w_in_range = int'(widx) < NUM_REGS;
        wsel_d = '0;
        for (int r = 0; r < NUM_REGS; r++)
            wsel_d[r] = commit && (|wstrb_d) && (int'(widx) == r);
    end
    // Read decode; indices past NUM_REGS fall through to zero.
    always_comb begin
        ridx = S_AXI_ARADDR[ADDR_WIDTH-1:2];
        r_in_range = int'(ridx) < NUM_REGS;
        rdata_d = '0;
        for (int r = 0; r < NUM_REGS; r++)
            if (int'(ridx) == r) rdata_d = regs_q[r];
    end
    // Write channel FSM: collect AW and W in any order, then hold B until accepted.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate_q <= W_COLLECT;
            awready_q <= 1'b1;
            wready_q <= 1'b1;
            aw_have_q <= 1'b0;
            w_have_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q <= OKAY;
            awaddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            pulse_q <= '0;
        end else begin
            pulse_q <= wsel_d;
            if (wstate_q == W_RESP) begin
                if (S_AXI_BREADY) begin
                    bvalid_q <= 1'b0;
                    awready_q <= 1'b1;
                    wready_q <= 1'b1;
                    wstate_q <= W_COLLECT;
                end
            end else if (commit) begin
                wstate_q <= W_RESP;
                awready_q <= 1'b0;
                wready_q <= 1'b0;
                aw_have_q <= 1'b0;
                w_have_q <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q <= w_in_range ? OKAY : OOR_RESP;
            end else begin
                if (aw_fire) begin
                    awaddr_q <= S_AXI_AWADDR;
                    aw_have_q <= 1'b1;
                    awready_q <= 1'b0;
                end
                if (w_fire) begin
                    wdata_q <= S_AXI_WDATA;
                    wstrb_q <= S_AXI_WSTRB;
                    w_have_q <= 1'b1;
                    wready_q <= 1'b0;
                end
            end
        end
    end
    // Register file: byte-lane update of the selected register on commit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                for (int b = 0; b < SW; b++)
                    if (wsel_d[r] && wstrb_d[b]) regs_q[r][b*8 +: 8] <= wdata_d[b*8 +: 8];
        end
    end
    // Read channel FSM: sample the register on AR handshake, hold R until accepted.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rstate_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q <= 1'b0;
            rresp_q <= OKAY;
            rdata_q <= '0;
        end else if (rstate_q == R_DATA) begin
            if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
                arready_q <= 1'b1;
                rstate_q <= R_IDLE;
            end
        end else if (S_AXI_ARVALID && arready_q) begin
            rdata_q <= rdata_d;
            rresp_q <= r_in_range ? OKAY : OOR_RESP;
            rvalid_q <= 1'b1;
            arready_q <= 1'b0;
            rstate_q <= R_DATA;
        end
    end
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY = wready_q;
    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RRESP = rresp_q;
    assign S_AXI_RDATA = rdata_q;
    assign reg_wr_pulse = pulse_q;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], awaddr_d[1:0]};
endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: scoreboard bench for axil_reg_slave (4-register and 3-register instances on shared stimulus).
module tb_axil_reg_slave;
    logic clk = 1'b0;
    always #5 clk = ~clk;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] SLV = 2'b10;
`else
    localparam logic [1:0] SLV = 2'b00;
`endif
    logic rst;
    logic [3:0] awaddr, araddr, wstrb;
    logic [31:0] wdata;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic [2:0] prot;
    logic awready0, wready0, bvalid0, arready0, rvalid0;
    logic [1:0] bresp0, rresp0;
    logic [31:0] rdata0;
    logic [127:0] regq0;
    logic [3:0] pulse0;
    logic awready1, wready1, bvalid1, arready1, rvalid1;
    logic [1:0] bresp1, rresp1;
    logic [31:0] rdata1;
    logic [95:0] regq1;
    logic [2:0] pulse1;
    int checks = 0;
    int errors = 0;
    int pc0 [4];
    int pc1 [3];
    int p0, p1, cnt;
    logic [1:0] bq0 [$];
    logic [1:0] bq1 [$];
    logic [33:0] rq0 [$];
    logic [33:0] rq1 [$];

    axil_reg_slave #(.NUM_REGS(4)) u0 (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready0),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready0),
        .S_AXI_BRESP(bresp0), .S_AXI_BVALID(bvalid0), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready0),
        .S_AXI_RDATA(rdata0), .S_AXI_RRESP(rresp0), .S_AXI_RVALID(rvalid0), .S_AXI_RREADY(rready),
        .reg_q(regq0), .reg_wr_pulse(pulse0)
    );

    axil_reg_slave #(.NUM_REGS(3)) u1 (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready1),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready1),
        .S_AXI_BRESP(bresp1), .S_AXI_BVALID(bvalid1), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready1),
        .S_AXI_RDATA(rdata1), .S_AXI_RRESP(rresp1), .S_AXI_RVALID(rvalid1), .S_AXI_RREADY(rready),
        .reg_q(regq1), .reg_wr_pulse(pulse1)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int awd, input int wd, input logic [1:0] e1, input int hold);
        logic aw_done, w_done, aw_hs, w_hs;
        int t;
        bq0.push_back(2'b00);
        bq1.push_back(e1);
        awaddr = a; wdata = d; wstrb = s;
        bready = (hold == 0);
        aw_done = 1'b0; w_done = 1'b0; t = 0;
        while (!(aw_done && w_done) && t < 50) begin
            awvalid = !aw_done && t >= awd;
            wvalid = !w_done && t >= wd;
            @(negedge clk);
            aw_hs = awvalid && awready0;
            w_hs = wvalid && wready0;
            @(posedge clk); #1;
            aw_done = aw_done | aw_hs;
            w_done = w_done | w_hs;
            t++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_handshake", {aw_done, w_done}, 2'b11);
        chk("bvalid_latency", bvalid0, 1'b1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("b_hold", {bvalid0, bresp0, awready0, wready0}, {1'b1, 2'b00, 1'b0, 1'b0});
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            bready = 1'b1;
        end
        t = 0;
        while (bvalid0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("b_done", bvalid0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1,
                      input logic [1:0] r1, input int hold);
        logic done, hs;
        int t;
        rq0.push_back({2'b00, e0});
        rq1.push_back({r1, e1});
        araddr = a;
        rready = (hold == 0);
        done = 1'b0; t = 0;
        while (!done && t < 50) begin
            arvalid = 1'b1;
            @(negedge clk);
            hs = arready0;
            @(posedge clk); #1;
            done = hs;
            t++;
        end
        arvalid = 1'b0;
        chk("ar_handshake", done, 1'b1);
        chk("rvalid_latency", rvalid0, 1'b1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("r_hold", {rvalid0, rresp0, rdata0, arready0}, {1'b1, 2'b00, e0, 1'b0});
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            rready = 1'b1;
        end
        t = 0;
        while (rvalid0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("r_done", rvalid0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; prot = 3'b000;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        for (int i = 0; i < 4; i++) pc0[i] = 0;
        for (int i = 0; i < 3; i++) pc1[i] = 0;
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    for (int i = 0; i < 4; i++) pc0[i] += int'(pulse0[i]);
                    for (int i = 0; i < 3; i++) pc1[i] += int'(pulse1[i]);
                    if (bvalid0 && bready) begin
                        if (bq0.size() == 0) chk("b0_unexpected", 1'b1, 1'b0);
                        else chk("bresp0", bresp0, bq0.pop_front());
                    end
                    if (bvalid1 && bready) begin
                        if (bq1.size() == 0) chk("b1_unexpected", 1'b1, 1'b0);
                        else chk("bresp1", bresp1, bq1.pop_front());
                    end
                    if (rvalid0 && rready) begin
                        if (rq0.size() == 0) chk("r0_unexpected", 1'b1, 1'b0);
                        else chk("rresp_rdata0", {rresp0, rdata0}, rq0.pop_front());
                    end
                    if (rvalid1 && rready) begin
                        if (rq1.size() == 0) chk("r1_unexpected", 1'b1, 1'b0);
                        else chk("rresp_rdata1", {rresp1, rdata1}, rq1.pop_front());
                    end
                end
            end
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_regs", {regq1, regq0}, '0);
        chk("reset_hs0", {awready0, wready0, arready0, bvalid0, rvalid0, pulse0}, {3'b111, 2'b00, 4'h0});
        chk("reset_hs1", {awready1, wready1, arready1, bvalid1, rvalid1}, 5'b11100);
        chk("reset_resp", {bresp0, rresp0, rdata0}, '0);
        wr(4'h0, 32'h1, 4'hF, 0, 0, 2'b00, 0);
        wr(4'h4, 32'h2, 4'hF, 0, 0, 2'b00, 0);
        wr(4'h8, 32'h3, 4'hF, 0, 0, 2'b00, 0);
        wr(4'hC, 32'h4, 4'hF, 0, 0, SLV, 0);
        rd(4'h0, 32'h1, 32'h1, 2'b00, 0);
        rd(4'h4, 32'h2, 32'h2, 2'b00, 0);
        rd(4'h8, 32'h3, 32'h3, 2'b00, 0);
        rd(4'hC, 32'h4, 32'h0, SLV, 0);
        chk("fill_regq0", regq0, 128'h00000004_00000003_00000002_00000001);
        chk("fill_regq1", regq1, 96'h00000003_00000002_00000001);
        wr(4'h0, 32'hAABBCCDD, 4'hF, 0, 0, 2'b00, 0);
        p0 = pc0[0]; p1 = pc0[1] + pc0[2] + pc0[3];
        wr(4'h1, 32'h11223344, 4'b0101, 0, 0, 2'b00, 0);
        chk("strobe_reg0", regq0[31:0], 32'hAA22CC44);
        chk("strobe_pulse0", pc0[0] - p0, 1);
        chk("strobe_other_pulses", pc0[1] + pc0[2] + pc0[3] - p1, 0);
        p0 = pc0[0] + pc0[1] + pc0[2] + pc0[3];
        wr(4'h4, 32'hFFFFFFFF, 4'h0, 0, 0, 2'b00, 0);
        chk("zero_strobe_reg1", regq0[63:32], 32'h2);
        chk("zero_strobe_pulse", pc0[0] + pc0[1] + pc0[2] + pc0[3] - p0, 0);
        wr(4'h4, 32'h5A5A0001, 4'hF, 3, 0, 2'b00, 0);
        chk("w_first_reg1", regq0[63:32], 32'h5A5A0001);
        wr(4'h6, 32'h5A5A0002, 4'hF, 0, 3, 2'b00, 0);
        chk("aw_first_reg1", regq0[63:32], 32'h5A5A0002);
        wr(4'h4, 32'h5A5A0003, 4'hF, 0, 0, 2'b00, 0);
        chk("same_cycle_reg1", regq0[63:32], 32'h5A5A0003);
        wr(4'h8, 32'h00000077, 4'hF, 0, 0, 2'b00, 5);
        rd(4'h8, 32'h77, 32'h77, 2'b00, 5);
        p1 = pc1[0] + pc1[1] + pc1[2];
        wr(4'hC, 32'hDEADBEEF, 4'hF, 0, 0, SLV, 0);
        chk("oor_regq1", regq1, 96'h00000077_5A5A0003_AA22CC44);
        chk("oor_pulse1", pc1[0] + pc1[1] + pc1[2] - p1, 0);
        chk("inrange_reg3", regq0[127:96], 32'hDEADBEEF);
        rd(4'hC, 32'hDEADBEEF, 32'h0, SLV, 0);
        fork
            wr(4'h0, 32'h12345678, 4'hF, 0, 0, 2'b00, 0);
            rd(4'h0, 32'hAA22CC44, 32'hAA22CC44, 2'b00, 0);
        join
        chk("simul_reg0", regq0[31:0], 32'h12345678);
        chk("queues_empty", bq0.size() + bq1.size() + rq0.size() + rq1.size(), 0);
        awaddr = 4'h4; awvalid = 1'b1;
        @(negedge clk);
        chk("mid_aw_ready", awready0, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_reset_regs", {regq1, regq0}, '0);
        chk("mid_reset_hs", {bvalid0, awready0, wready0, arready0, bvalid1, awready1, wready1, arready1}, 8'b01110111);
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cnt += int'(bvalid0) + int'(bvalid1);
            @(posedge clk); #1;
            wvalid = 1'b0;
        end
        chk("no_b_after_reset", cnt, 0);
        chk("regs_after_reset", regq0, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
